// File: rtl/jk_bank_sequencer_if.sv
// jk_bank_sequencer_if: command handshake bus into the JK bank sequencer
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [CNT_W-1:0] cmd_count;

    modport master (
        output cmd_valid, cmd_op, cmd_mask, cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mask, cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: drives one J/K edge per iteration into a JK bank and verifies the read-back Q
module jk_bank_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    jk_bank_sequencer_if.slave  cmd,
    input  logic [WIDTH-1:0]    q_fb_i,
    output logic [WIDTH-1:0]    j_out_o,
    output logic [WIDTH-1:0]    k_out_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [WIDTH-1:0]    err_bits_o
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic             done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;

    // J is asserted by SET and TOGGLE (op[1]); K by CLEAR and TOGGLE (op[0])
    function automatic logic [WIDTH-1:0] drive_j(input logic [1:0] op, input logic [WIDTH-1:0] m);
        return op[1] ? m : '0;
    endfunction

    function automatic logic [WIDTH-1:0] drive_k(input logic [1:0] op, input logic [WIDTH-1:0] m);
        return op[0] ? m : '0;
    endfunction

    // Bank value one edge after driving op/m onto a bank currently holding q
    function automatic logic [WIDTH-1:0] expect_q(input logic [1:0] op, input logic [WIDTH-1:0] m,
                                                  input logic [WIDTH-1:0] q);
        return op == OP_SET   ? (q | m)  :
               op == OP_CLEAR ? (q & ~m) :
               op == OP_TOGGLE ? (q ^ m) : q;
    endfunction

    assign cmd.cmd_ready = state_q == IDLE;
    assign busy_o        = state_q != IDLE;
    assign j_out_o       = j_q;
    assign k_out_o       = k_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign err_bits_o    = err_bits_q;

    // Next-state: accept in IDLE, pulse J/K for one cycle in DRIVE, verify Q in CHECK
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mask_d     = mask_q;
        iter_d     = iter_q;
        exp_d      = exp_q;
        j_d        = '0;
        k_d        = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_bits_d = err_bits_q;
        unique case (state_q)
            IDLE: if (cmd.cmd_valid) begin
                op_d    = cmd.cmd_op;
                mask_d  = cmd.cmd_mask;
                iter_d  = (cmd.cmd_op == OP_TOGGLE && cmd.cmd_count != '0) ? cmd.cmd_count : CNT_W'(1);
                exp_d   = expect_q(cmd.cmd_op, cmd.cmd_mask, q_fb_i);
                j_d     = drive_j(cmd.cmd_op, cmd.cmd_mask);
                k_d     = drive_k(cmd.cmd_op, cmd.cmd_mask);
                state_d = DRIVE;
            end
            DRIVE: state_d = CHECK;
            CHECK: if (q_fb_i != exp_q) begin
                err_d      = 1'b1;
                err_bits_d = q_fb_i ^ exp_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end else if (iter_q > CNT_W'(1)) begin
                iter_d  = iter_q - CNT_W'(1);
                exp_d   = q_fb_i ^ mask_q;
                j_d     = drive_j(op_q, mask_q);
                k_d     = drive_k(op_q, mask_q);
                state_d = DRIVE;
            end else begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any command in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_HOLD;
            mask_q     <= '0;
            iter_q     <= '0;
            exp_q      <= '0;
            j_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_bits_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mask_q     <= mask_d;
            iter_q     <= iter_d;
            exp_q      <= exp_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_bits_q <= err_bits_d;
        end
    end
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: directed checks of the sequencer against a behavioural JK bank
module tb_jk_bank_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] q_bank, j_out, k_out, err_bits, stuck0;
    logic       busy, done, err;
    int         total = 0;
    int         bad = 0;
    logic [1:0] q_op [4];
    logic [7:0] q_mask [4];
    logic [7:0] q_j [4];
    logic [7:0] q_k [4];

    jk_bank_sequencer_if #(.WIDTH(8), .CNT_W(8)) cif ();

    jk_bank_sequencer #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd        (cif),
        .q_fb_i     (q_bank),
        .j_out_o    (j_out),
        .k_out_o    (k_out),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .err_bits_o (err_bits)
    );

    always #5 clk = ~clk;

    // JK bank model: set/clear/toggle/hold, with optional stuck-at-0 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_bank <= '0;
        else       q_bank <= ((j_out & ~q_bank) | (~k_out & q_bank)) & ~stuck0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] mask, input logic [7:0] count);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_mask  = mask;
        cif.cmd_count = count;
    endtask

    initial begin
        stuck0        = '0;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_mask  = '0;
        cif.cmd_count = '0;
        q_op   = '{2'b10, 2'b01, 2'b11, 2'b00};
        q_mask = '{8'h30, 8'h01, 8'h0F, 8'hAA};
        q_j    = '{8'h30, 8'h00, 8'h0F, 8'h00};
        q_k    = '{8'h00, 8'h01, 8'h0F, 8'h00};
        repeat (2) @(negedge clk);
        chk("rst_ready", cif.cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_jk", {j_out, k_out}, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_err_bits", err_bits, 0);
        reset = 1'b0;
        // SET 0x0F from q=0
        issue(2'b10, 8'h0F, 8'd0);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        chk("set_j", j_out, 8'h0F);
        chk("set_k", k_out, 8'h00);
        chk("set_busy_drive", {busy, cif.cmd_ready}, 2'b10);
        @(negedge clk);
        chk("set_check_jk", {j_out, k_out}, 0);
        chk("set_busy_check", busy, 1);
        chk("set_q", q_bank, 8'h0F);
        @(negedge clk);
        chk("set_done", {done, err, busy, cif.cmd_ready}, 4'b1001);
        @(negedge clk);
        chk("set_done_pulse", done, 0);
        // Reset asserted mid-DRIVE
        issue(2'b10, 8'h0F, 8'd0);
        @(negedge clk);
        chk("mid_drive_j", j_out, 8'h0F);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_jk", {j_out, k_out}, 0);
        chk("async_rst_busy", {busy, cif.cmd_ready}, 2'b01);
        chk("async_rst_done_err", {done, err}, 0);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {busy, j_out, k_out}, 0);
        // TOGGLE 0x01 count 3 from q=0
        issue(2'b11, 8'h01, 8'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cif.cmd_valid = 1'b0;
            chk($sformatf("tog3_jk_%0d", i), {j_out, k_out}, (i % 2 == 0) ? 16'h0101 : 16'h0000);
            chk($sformatf("tog3_busy_%0d", i), {busy, done}, 2'b10);
        end
        @(negedge clk);
        chk("tog3_done", {done, err, busy}, 3'b100);
        chk("tog3_q", q_bank, 8'h01);
        // TOGGLE count 0 behaves as 1
        issue(2'b11, 8'h02, 8'd0);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        chk("tog0_jk", {j_out, k_out}, 16'h0202);
        @(negedge clk);
        chk("tog0_check", {busy, j_out, k_out}, 17'h10000);
        @(negedge clk);
        chk("tog0_done", {done, err, busy}, 3'b100);
        chk("tog0_q", q_bank, 8'h03);
        // HOLD mask 0xFF
        issue(2'b00, 8'hFF, 8'd0);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        chk("hold_drive", {busy, j_out, k_out}, 17'h10000);
        @(negedge clk);
        chk("hold_check", {busy, j_out, k_out}, 17'h10000);
        @(negedge clk);
        chk("hold_done", {done, err, busy}, 3'b100);
        chk("hold_q", q_bank, 8'h03);
        // Bit 2 stuck at 0: SET 0x04 fails
        stuck0 = 8'h04;
        issue(2'b10, 8'h04, 8'd0);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stuck_set_err", {done, err, busy}, 3'b110);
        chk("stuck_set_bits", err_bits, 8'h04);
        @(negedge clk);
        chk("stuck_err_pulse", {done, err}, 0);
        chk("stuck_bits_held", err_bits, 8'h04);
        // TOGGLE count 5 aborts after first failing check
        issue(2'b11, 8'h04, 8'd5);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
        chk("abort_drive", {j_out, k_out}, 16'h0404);
        @(negedge clk);
        @(negedge clk);
        chk("abort_err", {done, err, busy}, 3'b110);
        chk("abort_bits", err_bits, 8'h04);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort_dropped_%0d", i), {busy, done, j_out, k_out}, 0);
        end
        stuck0 = '0;
        // Four back-to-back commands with cmd_valid held high, q starts at 0x03
        issue(q_op[0], q_mask[0], 8'd0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c % 3 == 1) chk($sformatf("b2b_jk_%0d", c), {j_out, k_out}, {q_j[(c - 1) / 3], q_k[(c - 1) / 3]});
            else            chk($sformatf("b2b_jk0_%0d", c), {j_out, k_out}, 0);
            chk($sformatf("b2b_done_%0d", c), done, (c % 3 == 0) ? 1 : 0);
            if (c % 3 == 0) begin
                chk($sformatf("b2b_ready_%0d", c), cif.cmd_ready, 1);
                if (c < 12) issue(q_op[c / 3], q_mask[c / 3], 8'd0);
                else        cif.cmd_valid = 1'b0;
            end
        end
        chk("b2b_q", q_bank, 8'h3D);
        chk("b2b_err", err, 0);
        @(negedge clk);
        chk("b2b_idle", {busy, done}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
